// File: rtl/calendar_core.sv
// Binary seconds..year timekeeper with 1 Hz prescaler and field-write port.
// Define LEAP_YEAR_EN to give February 29 days when year[1:0]==0.
module calendar_core #(
  parameter int CLK_DIV = 50000000,
  parameter int CNT_W   = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_valid,
  input  logic [2:0] set_sel,
  input  logic [7:0] set_val,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [7:0] day,
  output logic [7:0] month,
  output logic [7:0] year,
  output logic       tick,
  output logic       set_err
);

  localparam logic [CNT_W-1:0] LP_TOP = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  logic             r_tick;
  logic             r_err;
  logic [7:0]       r_sec;
  logic [7:0]       r_min;
  logic [7:0]       r_hour;
  logic [7:0]       r_day;
  logic [7:0]       r_month;
  logic [7:0]       r_year;

  logic       w_req;
  logic       w_due;
  logic       w_svc;
  logic       w_legal;
  logic       w_wr;
  logic       w_leap_cur;
  logic       w_leap_new;
  logic [7:0] w_dim_cur;
  logic [7:0] w_dim_mon;
  logic [7:0] w_dim_yr;
  logic       w_c_min;
  logic       w_c_hour;
  logic       w_c_day;
  logic       w_c_mon;
  logic       w_c_yr;

  function automatic logic [7:0] f_dim(
    input logic [7:0] m,
    input logic       leap
  );
    case (m)
      8'd4, 8'd6, 8'd9, 8'd11: f_dim = 8'd30;
      8'd2:    f_dim = leap ? 8'd29 : 8'd28;
      default: f_dim = 8'd31;
    endcase
  endfunction

`ifdef LEAP_YEAR_EN
  assign w_leap_cur = (r_year[1:0] == 2'b00);
  assign w_leap_new = (set_val[1:0] == 2'b00);
`else
  assign w_leap_cur = 1'b0;
  assign w_leap_new = 1'b0;
`endif

  assign w_dim_cur = f_dim(r_month, w_leap_cur);
  assign w_dim_mon = f_dim(set_val, w_leap_cur);
  assign w_dim_yr  = f_dim(r_month, w_leap_new);

  // A write always wins the edge; a due tick is parked in r_pend.
  assign w_req = run & (r_cnt == LP_TOP);
  assign w_due = run & (w_req | r_pend);
  assign w_svc = w_due & ~set_valid;
  assign w_wr  = set_valid & w_legal;

  always_comb begin
    w_legal = 1'b0;
    case (set_sel)
      3'd0, 3'd1: w_legal = (set_val < 8'd60);
      3'd2:    w_legal = (set_val < 8'd24);
      3'd3:    w_legal = (set_val != 8'd0) && (set_val <= w_dim_cur);
      3'd4:    w_legal = (set_val != 8'd0) && (set_val <= 8'd12);
      3'd5:    w_legal = (set_val < 8'd100);
      default: w_legal = 1'b0;
    endcase
  end

  assign w_c_min  = (r_sec == 8'd59);
  assign w_c_hour = w_c_min & (r_min == 8'd59);
  assign w_c_day  = w_c_hour & (r_hour == 8'd23);
  assign w_c_mon  = w_c_day & (r_day == w_dim_cur);
  assign w_c_yr   = w_c_mon & (r_month == 8'd12);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
      r_tick <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= (!run || w_req) ? '0 : r_cnt + CNT_W'(1);
      r_pend <= w_due & set_valid;
      r_tick <= w_svc;
      r_err  <= set_valid & ~w_legal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec   <= 8'd0;
      r_min   <= 8'd0;
      r_hour  <= 8'd0;
      r_day   <= 8'd1;
      r_month <= 8'd1;
      r_year  <= 8'd0;
    end else if (w_wr) begin
      case (set_sel)
        3'd0: r_sec  <= set_val;
        3'd1: r_min  <= set_val;
        3'd2: r_hour <= set_val;
        3'd3: r_day  <= set_val;
        3'd4: begin
          r_month <= set_val;
          if (r_day > w_dim_mon) r_day <= w_dim_mon;
        end
        3'd5: begin
          r_year <= set_val;
          if (r_day > w_dim_yr) r_day <= w_dim_yr;
        end
        default: ;
      endcase
    end else if (w_svc) begin
      r_sec <= w_c_min ? 8'd0 : r_sec + 8'd1;
      if (w_c_min)
        r_min <= w_c_hour ? 8'd0 : r_min + 8'd1;
      if (w_c_hour)
        r_hour <= w_c_day ? 8'd0 : r_hour + 8'd1;
      if (w_c_day)
        r_day <= w_c_mon ? 8'd1 : r_day + 8'd1;
      if (w_c_mon)
        r_month <= w_c_yr ? 8'd1 : r_month + 8'd1;
      if (w_c_yr)
        r_year <= (r_year == 8'd99) ? 8'd0 : r_year + 8'd1;
    end
  end

  assign sec     = r_sec;
  assign min     = r_min;
  assign hour    = r_hour;
  assign day     = r_day;
  assign month   = r_month;
  assign year    = r_year;
  assign tick    = r_tick;
  assign set_err = r_err;

endmodule

// File: tb/tb_calendar_core.sv
// Bench for calendar_core: directed scenarios plus random run
// checked against a seconds-of-day calendar model.
module tb_calendar_core;

  localparam int CLK_DIV = 4;
  localparam int CNT_W   = 3;
`ifdef LEAP_YEAR_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif
  localparam logic [49:0] RST_VEC =
    {8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic       set_valid = 1'b0;
  logic [2:0] set_sel = 3'd0;
  logic [7:0] set_val = 8'd0;
  logic [7:0] sec, min, hour, day, month, year;
  logic       tick, set_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calendar_core #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .set_valid(set_valid), .set_sel(set_sel), .set_val(set_val),
    .sec(sec), .min(min), .hour(hour), .day(day),
    .month(month), .year(year), .tick(tick), .set_err(set_err)
  );

  typedef struct {
    int sec, min, hour, day, month, year, cnt;
    bit pend, tick, err;
  } st_t;

  st_t m = '{default: 0};

  function automatic int dim(int mo, int y);
    if (mo == 2) return (LEAP && (y % 4 == 0)) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic st_t rst_st();
    st_t s = '{default: 0};
    s.day = 1;
    s.month = 1;
    return s;
  endfunction

  function automatic st_t advance(st_t s);
    st_t n = s;
    int t;
    t = s.hour * 3600 + s.min * 60 + s.sec + 1;
    if (t == 86400) begin
      t = 0;
      n.day++;
      if (n.day > dim(n.month, n.year)) begin
        n.day = 1;
        n.month++;
        if (n.month > 12) begin
          n.month = 1;
          n.year = (n.year + 1) % 100;
        end
      end
    end
    n.hour = t / 3600;
    n.min = (t / 60) % 60;
    n.sec = t % 60;
    return n;
  endfunction

  function automatic st_t apply_write(st_t s, logic [2:0] sel,
                                      logic [7:0] v8);
    st_t n = s;
    int v = int'(v8);
    bit ok = 1'b0;
    case (sel)
      3'd0: begin ok = v < 60; if (ok) n.sec = v; end
      3'd1: begin ok = v < 60; if (ok) n.min = v; end
      3'd2: begin ok = v < 24; if (ok) n.hour = v; end
      3'd3: begin
        ok = v >= 1 && v <= dim(s.month, s.year);
        if (ok) n.day = v;
      end
      3'd4: begin
        ok = v >= 1 && v <= 12;
        if (ok) begin
          n.month = v;
          if (n.day > dim(v, s.year)) n.day = dim(v, s.year);
        end
      end
      3'd5: begin
        ok = v < 100;
        if (ok) begin
          n.year = v;
          if (n.day > dim(s.month, v)) n.day = dim(s.month, v);
        end
      end
      default: ok = 1'b0;
    endcase
    n.err = !ok;
    return n;
  endfunction

  function automatic st_t step(st_t s, logic r, logic v,
                               logic [2:0] sel, logic [7:0] val);
    st_t n = s;
    bit req, due;
    req = r && (s.cnt == CLK_DIV - 1);
    due = r && (req || s.pend);
    n.cnt = (r && !req) ? s.cnt + 1 : 0;
    n.pend = due && v;
    n.tick = due && !v;
    n.err = 1'b0;
    if (v) n = apply_write(n, sel, val);
    else if (n.tick) n = advance(n);
    return n;
  endfunction

  function automatic logic [49:0] vec(st_t s);
    return {8'(s.sec), 8'(s.min), 8'(s.hour), 8'(s.day),
            8'(s.month), 8'(s.year), s.tick, s.err};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= rst_st();
    else m <= step(m, run, set_valid, set_sel, set_val);
  end

  task automatic do_write(input logic [2:0] sel, input logic [7:0] val);
    set_sel = sel;
    set_val = val;
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({sec, min, hour, day, month, year, tick, set_err} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_async got %h exp %h",
               {sec, min, hour, day, month, year, tick, set_err}, RST_VEC);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({sec, min, hour, day, month, year, tick, set_err} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_hold got %h exp %h",
               {sec, min, hour, day, month, year, tick, set_err}, RST_VEC);
    end
  endtask

  task automatic test_prescale();
    int nt = 0;
    int first = -1;
    int last = -1;
    int bad_gap = 0;
    run = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        if (last >= 0 && c - last != CLK_DIV) bad_gap++;
        if (first < 0) first = c;
        nt++;
        last = c;
      end
    end
    checks++;
    if (nt != 4 || bad_gap != 0 || first != CLK_DIV) begin
      errors++;
      $display("FAIL prescale_ticks got n=%0d first=%0d gaps_bad=%0d exp 4/%0d/0",
               nt, first, bad_gap, CLK_DIV);
    end
    checks++;
    if ({sec, min, hour, day, month, year} !== RST_VEC[49:2] + {8'd4, 40'd0}) begin
      errors++;
      $display("FAIL prescale_fields got %h exp sec=4 rest reset",
               {sec, min, hour, day, month, year});
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sec, min, hour, day, month, year, tick, set_err} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_midcount got %h exp %h",
               {sec, min, hour, day, month, year, tick, set_err}, RST_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cascade();
    int n = 0;
    int hi = 0;
    do_write(3'd4, 8'd12);
    do_write(3'd3, 8'd31);
    do_write(3'd5, 8'd99);
    do_write(3'd2, 8'd23);
    do_write(3'd1, 8'd59);
    do_write(3'd0, 8'd59);
    run = 1'b1;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != CLK_DIV) begin
      errors++;
      $display("FAIL cascade_latency got %0d exp %0d", n, CLK_DIV);
    end
    checks++;
    if ({hour, min, sec, day, month, year} !==
        {8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0}) begin
      errors++;
      $display("FAIL cascade_fields got %h exp 000000010100",
               {hour, min, sec, day, month, year});
    end
    for (int i = 0; i < 3; i++) begin
      if (tick === 1'b1) hi++;
      @(negedge clk);
    end
    run = 1'b0;
    checks++;
    if (hi != 1) begin
      errors++;
      $display("FAIL cascade_tick_width got %0d exp 1", hi);
    end
  endtask

  task automatic wait_tick(input string nm);
    int n = 0;
    run = 1'b1;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    run = 1'b0;
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL %s_timeout got no tick exp tick", nm);
    end
  endtask

  task automatic test_leap();
    do_write(3'd5, 8'd24);
    do_write(3'd4, 8'd2);
    do_write(3'd3, 8'd28);
    do_write(3'd2, 8'd23);
    do_write(3'd1, 8'd59);
    do_write(3'd0, 8'd59);
    wait_tick("leap1");
    checks++;
    if ({day, month, year, hour, min, sec} !==
        {LEAP ? 8'd29 : 8'd1, LEAP ? 8'd2 : 8'd3, 8'd24, 24'd0}) begin
      errors++;
      $display("FAIL leap_first got %h exp leap=%0d", 
               {day, month, year, hour, min, sec}, LEAP);
    end
    do_write(3'd2, 8'd23);
    do_write(3'd1, 8'd59);
    do_write(3'd0, 8'd59);
    wait_tick("leap2");
    checks++;
    if ({day, month, year, hour, min, sec} !==
        {LEAP ? 8'd1 : 8'd2, 8'd3, 8'd24, 24'd0}) begin
      errors++;
      $display("FAIL leap_second got %h exp leap=%0d",
               {day, month, year, hour, min, sec}, LEAP);
    end
  endtask

  task automatic test_write_err();
    do_write(3'd3, 8'd15);
    do_write(3'd4, 8'd4);
    do_write(3'd3, 8'd31);
    checks++;
    if ({set_err, day, month} !== {1'b1, 8'd15, 8'd4}) begin
      errors++;
      $display("FAIL day31_apr got err=%0b day=%0d mon=%0d exp 1/15/4",
               set_err, day, month);
    end
    @(negedge clk);
    checks++;
    if (set_err !== 1'b0) begin
      errors++;
      $display("FAIL err_width got %0b exp 0", set_err);
    end
    do_write(3'd4, 8'd1);
    do_write(3'd3, 8'd31);
    do_write(3'd5, 8'd24);
    do_write(3'd4, 8'd2);
    checks++;
    if ({day, month, set_err} !== {LEAP ? 8'd29 : 8'd28, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL clamp_month got day=%0d mon=%0d err=%0b exp %0d/2/0",
               day, month, set_err, LEAP ? 29 : 28);
    end
    do_write(3'd5, 8'd23);
    checks++;
    if ({day, month, year} !== {8'd28, 8'd2, 8'd23}) begin
      errors++;
      $display("FAIL clamp_year got %0d/%0d/%0d exp 28/2/23",
               day, month, year);
    end
  endtask

  task automatic test_collision();
    do_write(3'd0, 8'd10);
    run = 1'b1;
    repeat (CLK_DIV - 1) @(negedge clk);
    do_write(3'd1, 8'd30);
    checks++;
    if ({min, sec, tick} !== {8'd30, 8'd10, 1'b0}) begin
      errors++;
      $display("FAIL collide_write got min=%0d sec=%0d tick=%0b exp 30/10/0",
               min, sec, tick);
    end
    @(negedge clk);
    checks++;
    if ({sec, tick} !== {8'd11, 1'b1}) begin
      errors++;
      $display("FAIL collide_pend got sec=%0d tick=%0b exp 11/1", sec, tick);
    end
  endtask

  task automatic test_back_to_back();
    repeat (CLK_DIV - 2) @(negedge clk);
    do_write(3'd2, 8'd5);
    do_write(3'd2, 8'd6);
    checks++;
    if ({hour, sec, tick} !== {8'd6, 8'd11, 1'b0}) begin
      errors++;
      $display("FAIL b2b_hold got hour=%0d sec=%0d tick=%0b exp 6/11/0",
               hour, sec, tick);
    end
    @(negedge clk);
    run = 1'b0;
    checks++;
    if ({sec, tick} !== {8'd12, 1'b1}) begin
      errors++;
      $display("FAIL b2b_serviced got sec=%0d tick=%0b exp 12/1", sec, tick);
    end
  endtask

  task automatic test_run_gate();
    int nt = 0;
    int n = 0;
    @(negedge clk);
    run = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tick === 1'b1) nt++;
    end
    checks++;
    if (nt != 0) begin
      errors++;
      $display("FAIL run_low_ticks got %0d exp 0", nt);
    end
    run = 1'b1;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    run = 1'b0;
    checks++;
    if (n != CLK_DIV) begin
      errors++;
      $display("FAIL run_restart got %0d exp %0d", n, CLK_DIV);
    end
    do_write(3'd0, 8'd17);
    do_write(3'd7, 8'd5);
    checks++;
    if ({set_err, sec, hour, day, month, year} !==
        {1'b1, 8'd17, 8'd6, 8'd28, 8'd2, 8'd23}) begin
      errors++;
      $display("FAIL sel7 got %h exp err and fields unchanged",
               {set_err, sec, hour, day, month, year});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      checks++;
      if ({sec, min, hour, day, month, year, tick, set_err} !== vec(m)) begin
        errors++;
        $display("FAIL random_%0d got %h exp %h", i,
                 {sec, min, hour, day, month, year, tick, set_err}, vec(m));
      end
      run = ($urandom_range(0, 9) != 0);
      set_valid = ($urandom_range(0, 4) == 0);
      set_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) set_val = 8'($urandom_range(0, 255));
      else set_val = 8'($urandom_range(0, 61));
    end
    set_valid = 1'b0;
    run = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_prescale();
    test_cascade();
    test_leap();
    test_write_err();
    test_collision();
    test_back_to_back();
    test_run_gate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
